// File: rtl/pwm_led_driver.sv
// Prescaled 8-bit LED PWM with shadow duty register and drain-on-disable FSM.
// Define GAMMA_PWM_EN to map captured duty through d*(d+1)>>8.
module pwm_led_driver #(
  parameter int unsigned DIV = 196
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       light,
  output logic       period_start,
  output logic [7:0] duty_active
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] PMAX = 16'(DIV - 1);
  localparam logic [7:0]  CMAX = 8'd254;

  state_t      state;
  state_t      state_nx;
  logic [15:0] prescaler;
  logic [15:0] prescaler_nx;
  logic [7:0]  pwm_cnt;
  logic [7:0]  pwm_cnt_nx;
  logic [7:0]  duty_pending;
  logic [7:0]  duty_pending_nx;
  logic [7:0]  duty_active_nx;
  logic [7:0]  duty_mapped;
  logic        light_nx;
  logic        ps_nx;
  logic        running;
  logic        tick;
  logic        boundary;

`ifdef GAMMA_PWM_EN
  logic [15:0] gamma_prod;

  assign gamma_prod  = {8'd0, duty_in} * ({8'd0, duty_in} + 16'd1);
  assign duty_mapped = gamma_prod[15:8];
`else
  assign duty_mapped = duty_in;
`endif

  assign running  = (state != OFF);
  assign tick     = running && (prescaler == PMAX);
  assign boundary = tick && (pwm_cnt == CMAX);

  always_comb begin
    state_nx        = state;
    prescaler_nx    = prescaler;
    pwm_cnt_nx      = pwm_cnt;
    duty_active_nx  = duty_active;
    ps_nx           = 1'b0;
    light_nx        = running && (pwm_cnt < duty_active);
    duty_pending_nx = duty_valid ? duty_mapped
                                 : duty_pending;

    if (running) begin
      prescaler_nx = tick ? 16'd0
                          : 16'(prescaler + 16'd1);
      if (tick)
        pwm_cnt_nx = boundary ? 8'd0
                              : 8'(pwm_cnt + 8'd1);
    end

    case (state)
      OFF: begin
        prescaler_nx = 16'd0;
        pwm_cnt_nx   = 8'd0;
        if (enable) begin
          state_nx       = RUN;
          duty_active_nx = duty_pending_nx;
          ps_nx          = 1'b1;
        end
      end
      RUN, DRAIN: begin
        // Enable level at the boundary decides: new period or stop.
        unique case (1'b1)
          boundary && enable: begin
            state_nx       = RUN;
            duty_active_nx = duty_pending;
            ps_nx          = 1'b1;
          end
          boundary && !enable: begin
            state_nx = OFF;
          end
          default: begin
            state_nx = enable ? RUN : DRAIN;
          end
        endcase
      end
      default: begin
        state_nx = OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= OFF;
      prescaler    <= 16'd0;
      pwm_cnt      <= 8'd0;
      duty_pending <= 8'd0;
      duty_active  <= 8'd0;
      light        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nx;
      prescaler    <= prescaler_nx;
      pwm_cnt      <= pwm_cnt_nx;
      duty_pending <= duty_pending_nx;
      duty_active  <= duty_active_nx;
      light        <= light_nx;
      period_start <= ps_nx;
    end
  end

endmodule

// File: doc/pwm_led_driver.md
Name: pwm_led_driver

Overview:
- Downstream stage of the breathing-light brightness generator: consumes its 8-bit duty value and produces the physical LED drive.
- Contains a prescaled 8-bit PWM engine with a shadow duty register, so duty changes take effect only at period boundaries and never glitch mid-period.
- An enable state machine drains the current period before switching the LED off. Optional perceptual gamma mapping.

Parameters:
- DIV, 196, clk cycles per PWM tick; legal range 1..65535. 100 MHz / 196 / 255 ≈ 2 kHz PWM.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  level; 1 = run PWM, 0 = stop after current period.
- duty_in  input  8  requested brightness, 0 = off, 255 = fully on.
- duty_valid  input  1  one-cycle qualifier; captures duty_in.
- light  output  1  registered LED drive.
- period_start  output  1  one-cycle pulse at the start of each PWM period.
- duty_active  output  8  duty currently applied (after optional gamma).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=OFF; prescaler=0; pwm_cnt=0; duty_pending=0; duty_active=0; light=0; period_start=0.
  - Reset has priority over every other input, including mid-period; the next period starts from scratch.
- Duty capture:
  - duty_valid=1 loads duty_pending <= map(duty_in) on any cycle in any state.
  - The last write before a boundary wins.
  - map() is identity unless GAMMA_PWM_EN is defined.
- Tick: in RUN/DRAIN, tick=1 when prescaler==DIV-1; prescaler then wraps to 0, else it increments. With DIV=1, tick=1 every cycle.
- PWM counter:
  - Counts 0..254 on ticks, so the period is 255 ticks (255*DIV clk cycles).
  - Boundary = tick && pwm_cnt==254. At a boundary: pwm_cnt <= 0 and duty_active <= duty_pending.
  - If duty_valid coincides with a boundary, the new value is captured into duty_pending but applied at the following boundary.
- States:
  - OFF: prescaler=0, pwm_cnt=0, light=0.
    - enable=1 -> RUN.
    - On that transition: duty_active <= duty_pending (or map(duty_in) if duty_valid in the same cycle); period_start pulses.
  - RUN: PWM active.
    - enable=0 -> DRAIN. Counters continue.
  - DRAIN: PWM continues unchanged.
    - At the boundary -> OFF; no duty_active update, no period_start.
    - enable=1 in DRAIN -> back to RUN, with no visible disturbance.
- light timing:
  - light(N+1) = (state(N)!=OFF) && (pwm_cnt(N) < duty_active(N)). One-cycle latency.
  - duty 0: light never 1. duty 255: light constantly 1 for the whole period, including across boundaries.
  - Duty d: exactly d ticks high per period, high ticks first.
- period_start:
  - Registered pulse, 1 in the cycle after a boundary taken while remaining in RUN, and in the cycle after an OFF->RUN transition.
  - Never 1 in OFF.
- duty_active output: reflects the register directly (0-cycle latency).

Optional Feature:
- Macro GAMMA_PWM_EN.
- Defined: map(d) = (d*(d+1))>>8, computed on a 16-bit product truncated to 8 bits. Examples: 0->0, 16->1, 128->64, 200->157, 255->255.
- Undefined: map(d) = d; no multiplier synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- DIV=1, reset, then enable=1 with duty_in=0x80 and duty_valid in the same cycle -> duty_active=128; light high for 128 consecutive cycles then low for 127; period_start pulses every 255 cycles.
- DIV=4, duty 0x40 running, write 0xC0 at mid-period -> current period keeps 64 ticks (256 clk) high; next period shows 192 ticks (768 clk) high; duty_active changes exactly at the boundary.
- duty=255 then duty=0 (DIV=1) -> light is 1 through entire periods with no gap at the wrap; after switching to 0, light stays 0 for the whole following period.
- enable dropped at pwm_cnt=10, duty=100, DIV=1 -> light finishes ticks 10..99 high, then low; state OFF after the boundary; no period_start; enable re-asserted in DRAIN -> period_start resumes normally.
- rst_n=0 asserted mid-period with light=1 -> light=0 and duty_active=0 the cycle after the reset edge; outputs stay 0 while rst_n=0 even with enable=1.
- GAMMA_PWM_EN defined, write 128 / 16 / 255 -> duty_active = 64 / 1 / 255 after the next boundary.
